// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared multi-cycle memory port.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic [15:0] i_rdata,
   output logic        i_done,
   output logic        i_stall,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_done,
   output logic        d_stall,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

   logic [1:0] state;
   logic [3:0] starve_cnt;
   logic       idle, sel_i, sel_d, mis_i, mis_d, fin_i, fin_d;

   assign idle  = (state == IDLE);
   // Instruction side only overrides data once the starvation budget is used up.
   assign sel_d = idle & d_req & ~(i_req & (starve_cnt == LIMIT));
   assign sel_i = idle & i_req & ~sel_d;
   assign mis_i = sel_i & i_addr[0];
   assign mis_d = sel_d & d_addr[0];
   assign fin_i = (state == BUSY_I) & mem_done;
   assign fin_d = (state == BUSY_D) & mem_done;

   assign i_done  = mis_i | fin_i;
   assign i_err   = mis_i;
   assign i_rdata = fin_i ? mem_rdata : 16'h0;
   assign i_stall = i_req & ~i_done;
   assign d_done  = mis_d | fin_d;
   assign d_err   = mis_d;
   assign d_rdata = fin_d ? mem_rdata : 16'h0;
   assign d_stall = d_req & ~d_done;

   // Driven from registered state only, so requests never reach mem_* combinationally.
   assign mem_req = ~idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         mem_wr     <= 1'b0;
         mem_addr   <= 16'h0;
         mem_wdata  <= 16'h0;
      end else if (idle) begin
         if (sel_i)
            starve_cnt <= 4'd0;
         else if (sel_d)
            starve_cnt <= !i_req ? 4'd0 :
                          (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
         if (sel_i && !i_addr[0]) begin
            state    <= BUSY_I;
            mem_addr <= i_addr;
            mem_wr   <= 1'b0;
         end else if (sel_d && !d_addr[0]) begin
            state     <= BUSY_D;
            mem_addr  <= d_addr;
            mem_wr    <= d_wr;
            mem_wdata <= d_wdata;
         end
      end else if (mem_done) begin
         state  <= IDLE;
         mem_wr <= 1'b0;
      end
   end

endmodule
